// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state, read-return pipeline
// entry, and the index-width helper.
package mem_arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] idx;
    } ret_entry_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side handshake plus memory-side bus of the shared memory port.
interface mem_port_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_data_in;
    logic                      mem_we;
    logic [DATA_W-1:0]         mem_data_out;

    modport master (
        output req, lock, we, addr, wdata, mem_data_out,
        input  gnt, rvalid, rdata, mem_addr, mem_data_in, mem_we
    );

    modport slave (
        input  req, lock, we, addr, wdata, mem_data_out,
        output gnt, rvalid, rdata, mem_addr, mem_data_in, mem_we
    );
endinterface

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate the request vector so ptr sits at
// bit 0, take the lowest set bit, then rotate the index back.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx,
    output logic               any
);
    logic [2*NUM_REQ-1:0] dbl_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic [IW-1:0]        rot_idx_s;
    logic [IW:0]          sum_s;
    logic                 found_s;

    // Rotate, priority-encode, rotate back
    always_comb begin
        dbl_s     = {req, req} >> ptr;
        rot_s     = dbl_s[NUM_REQ-1:0];
        any       = |req;
        found_s   = 1'b0;
        rot_idx_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rot_s[i] && !found_s) begin
                found_s   = 1'b1;
                rot_idx_s = IW'(i);
            end else begin
                found_s   = found_s;
            end
        end
        sum_s = {1'b0, rot_idx_s} + {1'b0, ptr};
        if (sum_s >= (IW+1)'(NUM_REQ)) begin
            sum_s = sum_s - (IW+1)'(NUM_REQ);
        end else begin
            sum_s = sum_s;
        end
        idx = sum_s[IW-1:0];
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt[i] = any && (idx == IW'(i));
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter with lock that shares one synchronous-read memory port
// among NUM_REQ requesters and steers read data back to the issuer.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    mem_port_arbiter_if.slave          bus,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       locked
);
    localparam int IW = idx_w(NUM_REQ);

    arb_state_t          state_r, state_s;
    logic [IW-1:0]       ptr_r, ptr_s, owner_r, owner_s;
    ret_entry_t          pipe_r [MEM_LATENCY];
    ret_entry_t          tail_s;
    logic [NUM_REQ-1:0]  pick_gnt_s, gnt_s, rvalid_s;
    logic [IW-1:0]       pick_idx_s, win_idx_s;
    logic                pick_any_s, win_s, mem_we_s;
    logic [ADDR_W-1:0]   mem_addr_s;
    logic [DATA_W-1:0]   mem_data_in_s, rdata_s;

    rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req (bus.req),
        .ptr (ptr_r),
        .gnt (pick_gnt_s),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

    // Next-state, grant and pointer update
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        owner_s   = owner_r;
        win_s     = 1'b0;
        win_idx_s = owner_r;
        gnt_s     = '0;
        if (reset) begin
            state_s = ARB;
        end else begin
            case (state_r)
                ARB: begin
                    if (pick_any_s) begin
                        win_s     = 1'b1;
                        win_idx_s = pick_idx_s;
                        gnt_s     = pick_gnt_s;
                        ptr_s     = (pick_idx_s == IW'(NUM_REQ-1)) ? '0 : pick_idx_s + IW'(1);
                        owner_s   = pick_idx_s;
                        state_s   = bus.lock[pick_idx_s] ? LOCKED : ARB;
                    end else begin
                        state_s = ARB;
                    end
                end
                LOCKED: begin
                    // Only the owner may use the port; its idle cycles keep the lock
                    if (bus.req[owner_r]) begin
                        win_s = 1'b1;
                        for (int i = 0; i < NUM_REQ; i++) begin
                            gnt_s[i] = (owner_r == IW'(i));
                        end
                        state_s = bus.lock[owner_r] ? LOCKED : ARB;
                    end else begin
                        state_s = LOCKED;
                    end
                end
                default: state_s = ARB;
            endcase
        end
    end

    // Memory mux follows the winner in the same cycle
    always_comb begin
        mem_we_s      = 1'b0;
        mem_addr_s    = '0;
        mem_data_in_s = '0;
        if (win_s) begin
            mem_we_s      = bus.we[win_idx_s];
            mem_addr_s    = bus.addr[int'(win_idx_s)*ADDR_W +: ADDR_W];
            mem_data_in_s = bus.wdata[int'(win_idx_s)*DATA_W +: DATA_W];
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Arbitration state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ARB;
            ptr_r   <= '0;
            owner_r <= '0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            owner_r <= owner_s;
        end
    end

    // Read-return shift register; tail lines up with memory data_out
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0] <= '{valid: win_s & ~mem_we_s, idx: 8'(win_idx_s)};
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    // Steer returning read data to its issuer
    always_comb begin
        tail_s   = pipe_r[MEM_LATENCY-1];
        rvalid_s = '0;
        rdata_s  = '0;
        if (!reset && tail_s.valid) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                rvalid_s[i] = (tail_s.idx == 8'(i));
            end
            rdata_s = bus.mem_data_out;
        end else begin
            rvalid_s = '0;
        end
    end

    assign bus.gnt         = gnt_s;
    assign bus.mem_we      = mem_we_s;
    assign bus.mem_addr    = mem_addr_s;
    assign bus.mem_data_in = mem_data_in_s;
    assign bus.rvalid      = rvalid_s;
    assign bus.rdata       = rdata_s;
    assign owner           = owner_r[$clog2(NUM_REQ)-1:0];
    assign locked          = (state_r == LOCKED);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a reference arbiter model predicts
// grants and queues expected read returns, which are popped when due.
module tb_mem_port_arbiter;
    localparam int N   = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    typedef struct {
        int          due;
        logic [N-1:0] oh;
        logic [31:0] data;
    } sb_t;

    logic        clk;
    logic        reset;
    logic        preload;
    logic [1:0]  owner;
    logic        locked;
    logic [31:0] mem [0:63];
    logic [31:0] mpipe [LAT];
    logic [31:0] exp_mem [0:63];
    sb_t         sb [$];
    int          checks;
    int          errors;
    int          cyc;
    int          m_ptr;
    int          m_owner;
    bit          m_locked;

    mem_port_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus.slave),
        .owner  (owner),
        .locked (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return 32'hA500_0000 | i;
    endfunction

    // Memory model with LAT-cycle synchronous read
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[5:0]] <= bus.mem_data_in;
        end
        mpipe[0] <= mem[bus.mem_addr[5:0]];
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign bus.mem_data_out = mpipe[LAT-1];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic r, input logic l, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        bus.req[i]            = r;
        bus.lock[i]           = l;
        bus.we[i]             = w;
        bus.addr[i*AW +: AW]  = a;
        bus.wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // One cycle: predict, compare, advance the model across the clock edge
    task automatic step();
        logic [N-1:0] eg;
        logic [N-1:0] exp_rv;
        logic [31:0]  exp_rd;
        logic [31:0]  wa;
        int           w;
        #1;
        eg = '0;
        w  = -1;
        if (!reset) begin
            if (m_locked) begin
                if (bus.req[m_owner]) w = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (w < 0 && bus.req[c]) w = c;
                end
            end
        end
        if (w >= 0) eg[w] = 1'b1;
        check_val("gnt", {29'd0, bus.gnt}, {29'd0, eg});
        check_val("mem_we", {31'd0, bus.mem_we}, (w >= 0) ? {31'd0, bus.we[w]} : 32'd0);
        check_val("mem_addr", bus.mem_addr, (w >= 0) ? bus.addr[w*AW +: AW] : 32'd0);
        if (w >= 0 && bus.we[w])
            check_val("mem_data_in", bus.mem_data_in, bus.wdata[w*DW +: DW]);
        exp_rv = '0;
        exp_rd = 32'd0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            if (!reset) begin
                exp_rv = sb[0].oh;
                exp_rd = sb[0].data;
            end
            void'(sb.pop_front());
        end
        check_val("rvalid", {29'd0, bus.rvalid}, {29'd0, exp_rv});
        if (exp_rv != '0) check_val("rdata", bus.rdata, exp_rd);
        if (!reset) begin
            check_val("locked", {31'd0, locked}, {31'd0, m_locked});
            check_val("owner", {30'd0, owner}, 32'(m_owner));
        end
        if (reset) begin
            m_locked = 1'b0;
            m_ptr    = 0;
            m_owner  = 0;
            sb.delete();
        end else if (w >= 0) begin
            wa = bus.addr[w*AW +: AW];
            if (bus.we[w]) exp_mem[wa[5:0]] = bus.wdata[w*DW +: DW];
            else sb.push_back('{due: cyc + LAT, oh: eg, data: exp_mem[wa[5:0]]});
            if (!m_locked) begin
                m_ptr   = (w + 1) % N;
                m_owner = w;
            end
            m_locked = bus.lock[w];
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        m_ptr    = 0;
        m_owner  = 0;
        m_locked = 1'b0;
        for (int i = 0; i < 64; i++) exp_mem[i] = init_val(i);
        reset   = 1'b1;
        preload = 1'b1;
        clear_all();
        step();
        step();
        reset   = 1'b0;
        preload = 1'b0;
        step();

        // All requesters reading continuously: strict rotation
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b0, 32'(8 + i), 32'd0);
        for (int c = 0; c < 6; c++) step();
        clear_all();
        for (int c = 0; c < LAT + 1; c++) step();

        // Write by 1 followed by read of the same address by 2
        set_req(1, 1'b1, 1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF);
        step();
        clear_all();
        set_req(2, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0);
        step();
        clear_all();
        for (int c = 0; c < LAT + 1; c++) step();

        // Requester 0 locks for 4 accesses while 2 waits, then releases
        set_req(2, 1'b1, 1'b0, 1'b0, 32'd20, 32'd0);
        for (int c = 0; c < 4; c++) begin
            set_req(0, 1'b1, 1'b1, 1'b0, 32'(30 + c), 32'd0);
            step();
        end
        set_req(0, 1'b1, 1'b0, 1'b1, 32'd34, 32'h1234_5678);
        step();
        set_req(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        clear_all();
        for (int c = 0; c < LAT + 1; c++) step();

        // Owner idles while locked; requester 1 must stay blocked
        set_req(0, 1'b1, 1'b1, 1'b0, 32'd34, 32'd0);
        step();
        set_req(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b1, 1'b0, 1'b1, 32'd40, 32'h5555_AAAA);
        step();
        step();
        set_req(0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0);
        step();
        step();
        clear_all();
        for (int c = 0; c < LAT + 1; c++) step();

        // Read in flight when reset hits is dropped; pointer restarts at 0
        set_req(1, 1'b1, 1'b0, 1'b0, 32'd9, 32'd0);
        step();
        clear_all();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b0, 32'(12 + i), 32'd0);
        step();
        clear_all();
        for (int c = 0; c < LAT + 1; c++) step();

        // Long idle with stray locks: no activity, pointer preserved
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b1, 1'b1, 32'd3, 32'hFFFF_FFFF);
        for (int c = 0; c < 10; c++) step();
        clear_all();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b0, 32'(16 + i), 32'd0);
        step();
        clear_all();
        for (int c = 0; c < LAT + 1; c++) step();

        check_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
